mod_sched: RTL and testbench
============================

// Module: mod_sched
// PURPOSE
//   Round-robin scheduler sharing one iterative repeated-subtraction modulo datapath
//   (load / enable / temp_lt_B interface) between NREQ requesters. It accepts one
//   operand pair at a time and sequences the datapath load and subtract steps.
//   It returns a MOD b to the winning requester. b==0 and runaway iteration counts
//   are reported as errors.
// PARAMETERS
//   NREQ      4      number of requesters (>=2)
//   WIDTH     32     operand/result width
//   MAX_ITER  1023   max subtract steps per job before abort with error
// PORTS
//   clk          input   1           rising-edge clock
//   reset        input   1           asynchronous, active-low reset
//   req_valid    input   NREQ        per-requester job request, held until req_ready
//   req_ready    output  NREQ        one-hot, 1-cycle accept pulse
//   req_a        input   NREQ*WIDTH  dividend, requester i at [i*WIDTH +: WIDTH]
//   req_b        input   NREQ*WIDTH  divisor, same packing
//   resp_valid   output  NREQ        one-hot, 1-cycle completion pulse to job owner
//   resp_result  output  WIDTH       a MOD b, valid with resp_valid
//   resp_err     output  1           1 = b==0 or MAX_ITER abort, valid with resp_valid
//   busy         output  1           1 whenever state != IDLE
//   dp_load      output  1           datapath: load dp_a/dp_b into temp this edge
//   dp_enable    output  1           datapath: temp <= temp - b this edge
//   dp_a         output  WIDTH       latched dividend to datapath
//   dp_b         output  WIDTH       latched divisor to datapath
//   dp_temp_lt_b input   1           datapath: current temp < b (combinational on temp reg)
//   dp_result    input   WIDTH       datapath: current temp
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, rr_ptr=0, iter=0, owner=0; all outputs 0.
//     Mid-job reset drops the job silently. No resp_valid is issued.
//     The datapath is not cleared. The next LOAD reinitialises it.
//   States: IDLE -> (LOAD | DONE); LOAD -> RUN; RUN -> (RUN | DONE); DONE -> IDLE.
//   IDLE: if any req_valid, grant the first asserted index at or after rr_ptr (wrapping).
//     Pulse req_ready[g]. Latch dp_a/dp_b from slice g. owner<=g.
//     If req_b slice g == 0: resp_err<=1, resp_result<=0, go DONE. Else go LOAD.
//     With no req_valid, stay in IDLE and keep all strobes 0.
//   LOAD: dp_load=1 for exactly one cycle. iter<=0. Go RUN.
//   RUN, evaluated each cycle (dp_enable is combinational on state and temp_lt_b):
//     dp_temp_lt_b=1: resp_result<=dp_result, resp_err<=0, go DONE. dp_enable=0.
//     dp_temp_lt_b=0, iter<MAX_ITER: dp_enable=1, iter<=iter+1.
//     dp_temp_lt_b=0, iter==MAX_ITER: resp_result<=dp_result (partial), resp_err<=1, go DONE.
//   DONE: resp_valid[owner]=1 for one cycle. rr_ptr<=(owner+1) mod NREQ. Go IDLE.
//     resp_result/resp_err hold until the next DONE.
//   Latency: accept in cycle T, resp_valid in cycle T+3+q, q=floor(a/b) (q<=MAX_ITER).
//     b==0: resp_valid in T+1. Max back-to-back throughput: one job per 4+q cycles.
//   dp_load and dp_enable are never high together and only for the owner's job.
//   Unsigned arithmetic throughout. iter width = $clog2(MAX_ITER+1).
//   req_valid changes during a job are ignored until return to IDLE. Only the
//     granted requester sees req_ready. Others stay pending and keep req_valid high.
//   Simultaneous requests: round-robin order from rr_ptr.
//   A requester that just finished has lowest priority next time.
// TESTING (bench models datapath: load/enable/temp register, temp_lt_b = temp<b)
//   Single job, req 0: a=10,b=3 -> req_ready[0] at T, dp_enable high 3 cycles,
//     resp_valid[0] at T+6, result=1, err=0.
//   a=2,b=7 on req 2 -> no dp_enable, resp_valid[2] at T+3, result=2, err=0.
//   b=0 on req 1, a=5 -> resp_valid[1] at T+1, err=1, result=0, dp_load never pulses.
//   All 4 req_valid held high from reset, a=9,b=4 each -> grants in order 0,1,2,3,0.
//     Each result=1. No grant overlaps a busy job.
//   MAX_ITER=8, a=100,b=1 -> 8 dp_enable cycles, then resp_valid with err=1, result=92.
//   Assert reset mid-RUN -> all outputs 0 immediately, no resp_valid.
//     After release, a new job a=17,b=5 -> result=2, owner served from rr_ptr=0.

Source files
------------

// File: rtl/mod_sched.sv
// Round-robin scheduler for one shared repeated-subtraction modulo datapath; resp 3+floor(a/b) cycles after accept (1 if b==0).
// Backpressure: one job in flight; other requesters hold req_valid until their one-cycle req_ready pulse.
module mod_sched #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  dp_load,
  output logic                  dp_enable,
  output logic [WIDTH-1:0]      dp_a,
  output logic [WIDTH-1:0]      dp_b,
  input  logic                  dp_temp_lt_b,
  input  logic [WIDTH-1:0]      dp_result
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [WIDTH-1:0]  dp_a_q, dp_a_d;
  logic [WIDTH-1:0]  dp_b_q, dp_b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              err_q, err_d;

  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     scan_idx;
  logic [WIDTH-1:0]  grant_a, grant_b;
  logic              accept;

  // First asserted requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == PW'(k)) begin
        grant_a = req_a[k*WIDTH +: WIDTH];
        grant_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by reset so no accept pulse leaks out while reset is held.
  assign accept = reset && (state_q == IDLE) && grant_vld;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    iter_d   = iter_q;
    dp_a_d   = dp_a_q;
    dp_b_d   = dp_b_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant_idx;
          dp_a_d  = grant_a;
          dp_b_d  = grant_b;
          if (grant_b == '0) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = DONE;
          end else begin
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        iter_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (dp_temp_lt_b) begin
          result_d = dp_result;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (iter_q < ITER_MAX) begin
          iter_d   = iter_q + 1'b1;
        end else begin
          result_d = dp_result;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      iter_q   <= '0;
      dp_a_q   <= '0;
      dp_b_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      iter_q   <= iter_d;
      dp_a_q   <= dp_a_d;
      dp_b_q   <= dp_b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k]  = accept && (grant_idx == PW'(k));
      resp_valid[k] = (state_q == DONE) && (owner_q == PW'(k));
    end
  end

  assign busy        = (state_q != IDLE);
  assign dp_load     = (state_q == LOAD);
  assign dp_enable   = (state_q == RUN) && !dp_temp_lt_b && (iter_q < ITER_MAX);
  assign dp_a        = dp_a_q;
  assign dp_b        = dp_b_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_mod_sched.sv
// Directed bench for mod_sched with a behavioural load/subtract datapath model.
module tb_mod_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int MI   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0] resp_valid;
  logic [W-1:0]    resp_result;
  logic            resp_err;
  logic            busy, dp_load, dp_enable;
  logic [W-1:0]    dp_a, dp_b;
  logic            dp_temp_lt_b;
  logic [W-1:0]    dp_result;
  logic [W-1:0]    temp = '0;

  int n_chk  = 0;
  int n_fail = 0;

  mod_sched #(.NREQ(NREQ), .WIDTH(W), .MAX_ITER(MI)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
    .busy(busy), .dp_load(dp_load), .dp_enable(dp_enable),
    .dp_a(dp_a), .dp_b(dp_b),
    .dp_temp_lt_b(dp_temp_lt_b), .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dp_load) temp <= dp_a;
    else if (dp_enable) temp <= temp - dp_b;
  end
  assign dp_temp_lt_b = (temp < dp_b);
  assign dp_result    = temp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_slice(input int r, input logic [31:0] a, input logic [31:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  task automatic run_job(input logic [3:0] mask, input int win, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int en,
                         input logic [31:0] res, input logic err, input int ld,
                         input string tag);
    bit acc  = 0;
    bit done = 0;
    int t0   = 0;
    int n_en = 0;
    int n_ld = 0;
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++) if (mask[r]) set_slice(r, a, b);
    req_valid = mask;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (dp_load && dp_enable) chk({tag, ".ld_en_excl"}, 1, 0);
      if (acc) begin
        n_en += int'(dp_enable);
        n_ld += int'(dp_load);
        if (req_ready != 0) chk({tag, ".rdy_in_job"}, req_ready, 0);
      end else if (req_ready != 0) begin
        chk({tag, ".grant"}, req_ready, 1 << win);
        acc = 1;
        t0  = n;
      end
      if (resp_valid != 0) begin
        chk({tag, ".owner"}, resp_valid, 1 << win);
        chk({tag, ".lat"}, n - t0, lat);
        chk({tag, ".result"}, resp_result, res);
        chk({tag, ".err"}, resp_err, err);
        chk({tag, ".enables"}, n_en, en);
        chk({tag, ".loads"}, n_ld, ld);
        done = 1;
        req_valid = '0;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (acc) req_valid[win] = 1'b0;
      end
    end
    if (!done) chk({tag, ".timeout"}, 0, 1);
    req_valid = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int g  = 0;
    int rs = 0;
    int n_en = 0;

    // All requesters pending while reset is held.
    reset = 1'b0;
    req_valid = '1;
    for (int r = 0; r < NREQ; r++) set_slice(r, 9, 4);
    repeat (2) @(negedge clk);
    chk("rst.req_ready", req_ready, 0);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.dp_strobes", {dp_load, dp_enable}, 0);
    chk("rst.dp_a", dp_a, 0);
    chk("rst.resp", {resp_err, resp_result}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int n = 0; n < 150 && rs < 5; n++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("rr.busy_at_grant", busy, 0);
        if (g < 5) chk($sformatf("rr.grant%0d", g), req_ready, 1 << exp_g[g]);
        g++;
      end
      if (resp_valid != 0) begin
        chk($sformatf("rr.owner%0d", rs), resp_valid, 1 << exp_g[rs]);
        chk($sformatf("rr.result%0d", rs), resp_result, 1);
        chk($sformatf("rr.err%0d", rs), resp_err, 0);
        rs++;
      end
      @(posedge clk); #1;
      if (g >= 5) req_valid = '0;
    end
    chk("rr.grants", g, 5);
    chk("rr.resps", rs, 5);
    req_valid = '0;

    run_job(4'b0001, 0, 10, 3, 6, 3, 1, 1'b0, 1, "j10_3");
    run_job(4'b0100, 2, 2, 7, 3, 0, 2, 1'b0, 1, "j2_7");
    run_job(4'b0010, 1, 5, 0, 1, 0, 0, 1'b1, 0, "b_zero");
    run_job(4'b1000, 3, 8, 1, 11, 8, 0, 1'b0, 1, "q_eq_max");
    run_job(4'b0001, 0, 100, 1, 11, 8, 92, 1'b1, 1, "abort");

    repeat (3) @(negedge clk);
    chk("hold.result", resp_result, 92);
    chk("hold.err", resp_err, 1);

    // Reset in the middle of a long RUN.
    @(posedge clk); #1;
    set_slice(1, 100, 1);
    req_valid = 4'b0010;
    for (int n = 0; n < 30 && n_en < 3; n++) begin
      @(negedge clk);
      if (dp_enable) n_en++;
      if (req_ready != 0) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
    end
    chk("mr.reached_run", n_en, 3);
    reset = 1'b0;
    #1;
    chk("mr.busy", busy, 0);
    chk("mr.dp_strobes", {dp_load, dp_enable}, 0);
    chk("mr.req_ready", req_ready, 0);
    chk("mr.resp_valid", resp_valid, 0);
    chk("mr.dp_a", dp_a, 0);
    chk("mr.resp", {resp_err, resp_result}, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("mr.no_resp%0d", n), resp_valid, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_job(4'b1001, 0, 17, 5, 6, 3, 2, 1'b0, 1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
